// File: rtl/input_debouncer_pkg.sv
// Shared constants and types for the five-channel board input debouncer.
package input_debouncer_pkg;

   // 1 ms of stable input at a 50 MHz system clock
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

   // Board push-buttons pull the pin low when pressed
   localparam bit BTN_ACTIVE_LOW_DEFAULT = 1'b1;

   localparam int unsigned NUM_CHANNELS = 5;

   // Position of each channel inside the internal channel vectors
   typedef enum int unsigned {
      CH_NEXT_LED = 0,
      CH_MODE     = 1,
      CH_CYCLIC   = 2,
      CH_SW_H     = 3,
      CH_SW_L     = 4
   } channel_e;

   // Counter width able to hold 0..n-1
   function automatic int unsigned count_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/input_debouncer_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle strobe on each rising edge of the level.
module debounce_channel
   import input_debouncer_pkg::*;
#(
   parameter int unsigned N = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic async_reset,
   input  logic pin,
   output logic level,
   output logic pulse
);

   localparam int unsigned W = count_width(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic          sync_meta;
   logic          sync_out;
   logic [W-1:0]  count;

   // Bring the asynchronous pin into the clock domain
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
      end else begin
         sync_meta <= pin;
         sync_out  <= sync_meta;
      end
   end

   // Accept a new level only after it has differed for N consecutive cycles
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         count <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (sync_out == level) begin
            count <= '0;
         end else if (count == LAST) begin
            count <= '0;
            level <= sync_out;
            pulse <= sync_out;
         end else begin
            count <= count + W'(1);
         end
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Debounces three push-buttons and two slide-switches. Buttons are turned
// into logical "1 = pressed" levels before synchronisation so every channel
// works on the same polarity.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter bit          BTN_ACTIVE_LOW  = BTN_ACTIVE_LOW_DEFAULT
) (
   input  logic clk,
   input  logic async_reset,
   input  logic btn_next_led_raw,
   input  logic btn_mode_raw,
   input  logic btn_cyclic_raw,
   input  logic sw_h_raw,
   input  logic sw_l_raw,
   output logic btn_next_led_debounded,
   output logic btn_mode_debounced,
   output logic btn_cyclic_debounced,
   output logic btn_next_led_pulse,
   output logic btn_mode_pulse,
   output logic btn_cyclic_pulse,
   output logic sw_h_debounced,
   output logic sw_l_debounced
);

   localparam logic BTN_INVERT = BTN_ACTIVE_LOW;

   logic [NUM_CHANNELS-1:0] logical_pins;
   logic                    sw_h_pulse_unused;
   logic                    sw_l_pulse_unused;

   assign logical_pins[CH_NEXT_LED] = btn_next_led_raw ^ BTN_INVERT;
   assign logical_pins[CH_MODE]     = btn_mode_raw ^ BTN_INVERT;
   assign logical_pins[CH_CYCLIC]   = btn_cyclic_raw ^ BTN_INVERT;
   assign logical_pins[CH_SW_H]     = sw_h_raw;
   assign logical_pins[CH_SW_L]     = sw_l_raw;

   debounce_channel #(.N(DEBOUNCE_CYCLES)) u_next_led (
      .clk         (clk),
      .async_reset (async_reset),
      .pin         (logical_pins[CH_NEXT_LED]),
      .level       (btn_next_led_debounded),
      .pulse       (btn_next_led_pulse)
   );

   debounce_channel #(.N(DEBOUNCE_CYCLES)) u_mode (
      .clk         (clk),
      .async_reset (async_reset),
      .pin         (logical_pins[CH_MODE]),
      .level       (btn_mode_debounced),
      .pulse       (btn_mode_pulse)
   );

   debounce_channel #(.N(DEBOUNCE_CYCLES)) u_cyclic (
      .clk         (clk),
      .async_reset (async_reset),
      .pin         (logical_pins[CH_CYCLIC]),
      .level       (btn_cyclic_debounced),
      .pulse       (btn_cyclic_pulse)
   );

   debounce_channel #(.N(DEBOUNCE_CYCLES)) u_sw_h (
      .clk         (clk),
      .async_reset (async_reset),
      .pin         (logical_pins[CH_SW_H]),
      .level       (sw_h_debounced),
      .pulse       (sw_h_pulse_unused)
   );

   debounce_channel #(.N(DEBOUNCE_CYCLES)) u_sw_l (
      .clk         (clk),
      .async_reset (async_reset),
      .pin         (logical_pins[CH_SW_L]),
      .level       (sw_l_debounced),
      .pulse       (sw_l_pulse_unused)
   );

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with N=4 and active-low buttons.
// The reference model keeps a window of past logical pin samples per channel
// and flips a channel's level once the N samples that have reached the
// synchroniser output all disagree with the current level.
module tb_input_debouncer;

   localparam int N = 4;

   logic clk = 1'b0;
   logic async_reset;
   logic btn_next_led_raw, btn_mode_raw, btn_cyclic_raw, sw_h_raw, sw_l_raw;
   logic btn_next_led_debounded, btn_mode_debounced, btn_cyclic_debounced;
   logic btn_next_led_pulse, btn_mode_pulse, btn_cyclic_pulse;
   logic sw_h_debounced, sw_l_debounced;

   int vectors = 0;
   int miscompares = 0;

   // Logical pin vector: bit0 next_led, bit1 mode, bit2 cyclic, bit3 sw_h, bit4 sw_l
   logic [4:0] drv;
   logic [4:0] hist [0:N+1];
   logic [4:0] exp_level;
   logic [2:0] exp_pulse;

   wire [4:0] dut_level = {sw_l_debounced, sw_h_debounced, btn_cyclic_debounced,
                           btn_mode_debounced, btn_next_led_debounded};
   wire [2:0] dut_pulse = {btn_cyclic_pulse, btn_mode_pulse, btn_next_led_pulse};

   input_debouncer #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b1)) dut (
      .clk                    (clk),
      .async_reset            (async_reset),
      .btn_next_led_raw       (btn_next_led_raw),
      .btn_mode_raw           (btn_mode_raw),
      .btn_cyclic_raw         (btn_cyclic_raw),
      .sw_h_raw               (sw_h_raw),
      .sw_l_raw               (sw_l_raw),
      .btn_next_led_debounded (btn_next_led_debounded),
      .btn_mode_debounced     (btn_mode_debounced),
      .btn_cyclic_debounced   (btn_cyclic_debounced),
      .btn_next_led_pulse     (btn_next_led_pulse),
      .btn_mode_pulse         (btn_mode_pulse),
      .btn_cyclic_pulse       (btn_cyclic_pulse),
      .sw_h_debounced         (sw_h_debounced),
      .sw_l_debounced         (sw_l_debounced)
   );

   // Free-running 100 MHz-style clock
   always #5 clk = ~clk;

   // Buttons are driven active-low on the pins, switches active-high
   task automatic drive_pins(input logic [4:0] p);
      drv = p;
      {sw_l_raw, sw_h_raw, btn_cyclic_raw, btn_mode_raw, btn_next_led_raw} = p ^ 5'b00111;
   endtask

   task automatic model_reset();
      for (int i = 0; i <= N + 1; i++) hist[i] = '0;
      exp_level = '0;
      exp_pulse = '0;
   endtask

   // Drive pins, take one clock edge, advance the model, settle 1 time unit
   task automatic step(input logic [4:0] p);
      logic all_diff;
      drive_pins(p);
      @(posedge clk);
      for (int i = N + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = p;
      exp_pulse = '0;
      for (int c = 0; c < 5; c++) begin
         all_diff = 1'b1;
         for (int i = 2; i <= N + 1; i++)
            if (hist[i][c] == exp_level[c]) all_diff = 1'b0;
         if (all_diff) begin
            exp_level[c] = ~exp_level[c];
            if (c < 3 && exp_level[c]) exp_pulse[c] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'b00000);
   endtask

   task automatic test_reset();
      vectors++;
      if (dut_level !== 5'b0 || dut_pulse !== 3'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_hold level=%b pulse=%b expected 00000/000", dut_level, dut_pulse);
      end
      #3 async_reset = 1'b0;
      model_reset();
      for (int i = 0; i < N + 4; i++) begin
         step(5'b11111);
         vectors++;
         if (dut_level !== exp_level || dut_pulse !== exp_pulse) begin
            miscompares++;
            $display("[TB] FAIL all_active i=%0d level=%b pulse=%b expected %b/%b",
                     i, dut_level, dut_pulse, exp_level, exp_pulse);
         end
      end
      vectors++;
      if (dut_level !== 5'b11111) begin
         miscompares++;
         $display("[TB] FAIL all_active_final level=%b expected 11111", dut_level);
      end
      #2 async_reset = 1'b1;
      #1;
      vectors++;
      if (dut_level !== 5'b0 || dut_pulse !== 3'b0) begin
         miscompares++;
         $display("[TB] FAIL async_clear level=%b pulse=%b expected 00000/000", dut_level, dut_pulse);
      end
      drive_pins(5'b00000);
      #1 async_reset = 1'b0;
      model_reset();
      idle(N + 3);
   endtask

   task automatic test_latency();
      int rise_idx = -1, pulse_idx = -1, pulse_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(5'b00010);
         vectors++;
         if (dut_level !== exp_level || dut_pulse !== exp_pulse) begin
            miscompares++;
            $display("[TB] FAIL latency_model i=%0d level=%b pulse=%b expected %b/%b",
                     i, dut_level, dut_pulse, exp_level, exp_pulse);
         end
         if (btn_mode_debounced && rise_idx < 0) rise_idx = i;
         if (btn_mode_pulse) begin
            pulse_cnt++;
            if (pulse_idx < 0) pulse_idx = i;
         end
      end
      vectors++;
      if (rise_idx != 5 || pulse_idx != 5 || pulse_cnt != 1) begin
         miscompares++;
         $display("[TB] FAIL mode_latency rise=%0d pulse_at=%0d pulses=%0d expected 5/5/1",
                  rise_idx, pulse_idx, pulse_cnt);
      end
      idle(N + 3);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 10; i++) begin
         step((i < 3) ? 5'b01000 : 5'b00000);
         vectors++;
         if (sw_h_debounced !== 1'b0 || dut_level !== exp_level) begin
            miscompares++;
            $display("[TB] FAIL sw_h_glitch i=%0d level=%b expected %b", i, dut_level, exp_level);
         end
      end
   endtask

   task automatic test_release();
      int fall_idx = -1, pulse_cnt = 0;
      for (int i = 0; i < 20; i++) step(5'b00001);
      for (int i = 0; i < 10; i++) begin
         step(5'b00000);
         vectors++;
         if (dut_level !== exp_level || dut_pulse !== exp_pulse) begin
            miscompares++;
            $display("[TB] FAIL release_model i=%0d level=%b pulse=%b expected %b/%b",
                     i, dut_level, dut_pulse, exp_level, exp_pulse);
         end
         if (!btn_next_led_debounded && fall_idx < 0) fall_idx = i;
         if (btn_next_led_pulse) pulse_cnt++;
      end
      vectors++;
      if (fall_idx != 5 || pulse_cnt != 0) begin
         miscompares++;
         $display("[TB] FAIL release_latency fall=%0d pulses=%0d expected 5/0", fall_idx, pulse_cnt);
      end
   endtask

   task automatic test_simultaneous();
      int rise_sw = -1, rise_btn = -1;
      for (int i = 0; i < 8; i++) begin
         step(5'b10100);
         if (sw_l_debounced && rise_sw < 0) rise_sw = i;
         if (btn_cyclic_debounced && rise_btn < 0) rise_btn = i;
      end
      vectors++;
      if (rise_sw != 5 || rise_btn != 5) begin
         miscompares++;
         $display("[TB] FAIL simultaneous sw_l_rise=%0d cyclic_rise=%0d expected 5/5", rise_sw, rise_btn);
      end
      idle(N + 3);
   endtask

   task automatic test_reset_midcount();
      int rise_idx = -1, pulse_cnt = 0;
      for (int i = 0; i < 4; i++) step(5'b00001);
      async_reset = 1'b1;
      #1;
      vectors++;
      if (dut_level !== 5'b0 || dut_pulse !== 3'b0) begin
         miscompares++;
         $display("[TB] FAIL midcount_reset level=%b pulse=%b expected 00000/000", dut_level, dut_pulse);
      end
      @(posedge clk);
      #3 async_reset = 1'b0;
      model_reset();
      for (int i = 0; i < 9; i++) begin
         step(5'b00001);
         vectors++;
         if (dut_level !== exp_level || dut_pulse !== exp_pulse) begin
            miscompares++;
            $display("[TB] FAIL post_reset_model i=%0d level=%b pulse=%b expected %b/%b",
                     i, dut_level, dut_pulse, exp_level, exp_pulse);
         end
         if (btn_next_led_debounded && rise_idx < 0) rise_idx = i;
         if (btn_next_led_pulse) pulse_cnt++;
      end
      vectors++;
      if (rise_idx != N + 1 || pulse_cnt != 1) begin
         miscompares++;
         $display("[TB] FAIL post_reset_latency rise=%0d pulses=%0d expected %0d/1", rise_idx, pulse_cnt, N + 1);
      end
      idle(N + 3);
   endtask

   task automatic test_random();
      logic [4:0] p = 5'b00000;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < 5; c++)
            if ($urandom_range(0, 5) == 0) p[c] = ~p[c];
         step(p);
         vectors++;
         if (dut_level !== exp_level || dut_pulse !== exp_pulse) begin
            miscompares++;
            $display("[TB] FAIL random i=%0d pins=%b level=%b pulse=%b expected %b/%b",
                     i, p, dut_level, dut_pulse, exp_level, exp_pulse);
         end
      end
   endtask

   // Scenario sequence
   initial begin
      async_reset = 1'b1;
      drive_pins(5'b00000);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_latency();
      test_glitch();
      test_release();
      test_simultaneous();
      test_reset_midcount();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
